uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte transmit queue between the CPU IO write port and the UART emitter. Accepts byte writes
//  to the UART IO word without stalling the CPU, buffers them, and drains them to the UART over a
//  valid/ready handshake. Exposes full/level/overflow status for the IO read mux (busy bit 9).
// PARAMETERS
//  DEPTH   16  storage entries, power of 2, >=2
//  AW      4   log2(DEPTH)
//  DW      8   data width (byte)
// PORTS
//  clk       in   1      system clock; single clock domain
//  resetn    in   1      asynchronous, active-low reset
//  wr_valid  in   1      push strobe (IO write decoded to UART word); one byte per cycle
//  wr_data   in   DW     byte to push (IO write data [7:0])
//  full      out  1      storage full; drives IO status busy bit
//  empty     out  1      storage empty and output stage empty
//  level     out  AW+1   storage count + tx_valid, range 0..DEPTH+1
//  ovf       out  1      sticky: a push was dropped
//  ovf_clr   in   1      clears ovf
//  tx_data   out  DW     byte presented to the UART
//  tx_valid  out  1      tx_data is valid
//  tx_ready  in   1      UART accepts tx_data this cycle
// BEHAVIOUR
//  - Reset (resetn=0, async): rd/wr pointers 0, tx_valid=0, tx_data=0, ovf=0 -> full=0, empty=1,
//    level=0. Reset mid-operation discards all queued bytes, including the output-stage byte.
//  - Storage: DEPTH-entry array, pointers AW+1 bits (wrap bit); full = ptrs equal except MSB;
//    storage-empty = ptrs equal. Pointers wrap modulo 2*DEPTH naturally.
//  - Pop: transfer on tx_valid & tx_ready. tx_data/tx_valid registered; tx_data must hold stable
//    while tx_valid & !tx_ready.
//  - Output stage refill when (!tx_valid | tx_ready):
//      storage non-empty -> load head entry, advance rd ptr, tx_valid=1;
//      storage empty & wr_valid -> bypass: load wr_data directly, storage untouched, tx_valid=1;
//      else tx_valid=0.
//  - Push: when wr_valid and not bypassed: if !full write at wr ptr, advance; if full drop byte,
//    set ovf. Full is evaluated on the current-cycle value; a same-cycle pop does not free a slot.
//  - Latency: write into idle queue -> tx_valid=1 the following cycle (1 cycle). FIFO order strict.
//  - ovf: set on drop; cleared by ovf_clr; set wins if both in the same cycle.
//  - Outputs full/empty/level combinational from registers only (no input-to-output paths).
//  - level width AW+1 covers DEPTH+1 for DEPTH>=2.
// STRUCTURE
//  - Shared include io_defs.vh: IO word-address bit of UART data (bit 1), UART status word
//    (bit 2), busy status bit position (9), UART_TXQ_DEPTH default.
//  - Sub-module txq_mem: DEPTH x DW array, synchronous write, asynchronous read by rd ptr.
//  - Top holds pointers, output register, bypass/refill mux, ovf flag.
// TESTING
//  1. Reset, tx_ready=1, push 0x41 once -> next cycle tx_valid=1, tx_data=0x41; after accept
//     empty=1, level=0.
//  2. tx_ready=0, push 0x00..0x11 (18 bytes) -> first to output stage, 16 stored, full=1,
//     level=17, 0x11 dropped, ovf=1; release tx_ready -> 0x00..0x10 emitted in order, no gaps.
//  3. Full queue, tx_ready=1, push 0xAA in same cycle as pop -> 0xAA dropped, ovf=1, level 17->16.
//  4. tx_valid=1, tx_ready=0 for 5 cycles while pushing -> tx_data unchanged for all 5 cycles.
//  5. Assert ovf_clr with ovf=1 and no drop -> ovf=0; ovf_clr together with a dropped push ->
//     ovf stays 1.
//  6. Queue at level 9 with tx_valid=1; pulse resetn low mid-cycle -> outputs reset immediately;
//     after release, push 0x55 -> tx_data=0x55 (no stale bytes).

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// rtl/uart_tx_queue_pkg.sv - shared constants for the UART transmit byte queue
package uart_tx_queue_pkg;

    localparam int UART_TXQ_DEPTH   = 16;
    localparam int UART_TXQ_AW      = 4;
    localparam int UART_TXQ_DW      = 8;

    // IO map: word-address bits selecting the UART data/status words, busy bit in status
    localparam int IO_UART_DATA_BIT = 1;
    localparam int IO_UART_STAT_BIT = 2;
    localparam int IO_BUSY_BIT      = 9;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_MEM   = 2'd1,
        SRC_BYPASS = 2'd2
    } txq_src_e;

endpackage

// File: rtl/txq_mem.sv
// rtl/txq_mem.sv - queue storage, synchronous write, asynchronous read
module txq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte transmit queue feeding the UART over a valid/ready output stage
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEPTH,
    parameter int AW    = UART_TXQ_AW,
    parameter int DW    = UART_TXQ_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_tx_data;
    logic          r_tx_valid;
    logic          r_ovf;

    logic          w_st_empty;
    logic          w_full;
    logic          w_refill;
    logic          w_bypass;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_head;
    logic [AW:0]   w_st_count;
    txq_src_e      w_src;

    assign w_st_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full is judged on this cycle's pointers, so a simultaneous pop never makes room for a push
    assign w_refill   = !r_tx_valid || tx_ready;
    assign w_bypass   = w_refill && w_st_empty && wr_valid;
    assign w_push     = wr_valid && !w_bypass && !w_full;
    assign w_drop     = wr_valid && !w_bypass && w_full;

    always_comb begin
        w_src = SRC_NONE;
        if (w_refill) begin
            if (!w_st_empty) begin
                w_src = SRC_MEM;
            end else if (wr_valid) begin
                w_src = SRC_BYPASS;
            end
        end
    end

    txq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_refill) begin
                case (w_src)
                    SRC_MEM: begin
                        r_tx_data  <= w_head;
                        r_tx_valid <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                    end
                    SRC_BYPASS: begin
                        r_tx_data  <= wr_data;
                        r_tx_valid <= 1'b1;
                    end
                    default: begin
                        r_tx_valid <= 1'b0;
                    end
                endcase
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_st_count = r_wr_ptr - r_rd_ptr;

    assign full     = w_full;
    assign empty    = w_st_empty && !r_tx_valid;
    assign level    = w_st_count + {{AW{1'b0}}, r_tx_valid};
    assign ovf      = r_ovf;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
